// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency multiply/divide unit in E, owns HI/LO.
// Define MULDIV_MAC_EN to enable madd/maddu/msub/msubu (ops 7-10).
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MAC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic          valid;
  logic          is_mul;
  logic [63:0]   sprod;
  logic [63:0]   uprod;
  logic [63:0]   res;
  logic          wr;

  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        ub;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic               dovf;

  // Classify the incoming op: launchable, and which latency
  always_comb begin
    valid  = 1'b0;
    is_mul = 1'b0;
    unique case (1'b1)
      md_op == OP_MULT,
      md_op == OP_MULTU: begin
        valid  = 1'b1;
        is_mul = 1'b1;
      end
      md_op == OP_DIV,
      md_op == OP_DIVU: valid = 1'b1;
`ifdef MULDIV_MAC_EN
      md_op == OP_MADD,
      md_op == OP_MADDU,
      md_op == OP_MSUB,
      md_op == OP_MSUBU: begin
        valid  = 1'b1;
        is_mul = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign sprod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign uprod = {32'd0, a_q} * {32'd0, b_q};

  // Divide by 1 for /0 and min/-1 so the divider never overflows;
  // min/1 already yields the architected q=min, r=0.
  assign dovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign sa   = $signed(a_q);
  assign sb   = ((b_q == 32'd0) || dovf) ? 32'sd1 : $signed(b_q);
  assign sq   = sa / sb;
  assign sr   = sa % sb;
  assign ub   = (b_q == 32'd0) ? 32'd1 : b_q;
  assign uq   = a_q / ub;
  assign ur   = a_q % ub;

  // Result of the latched op; HI/LO hold when wr is low
  always_comb begin
    res = {hi, lo};
    wr  = 1'b0;
    unique case (1'b1)
      op_q == OP_MULT: begin
        res = sprod;
        wr  = 1'b1;
      end
      op_q == OP_MULTU: begin
        res = uprod;
        wr  = 1'b1;
      end
      op_q == OP_DIV: begin
        res = {sr, sq};
        wr  = (b_q != 32'd0);
      end
      op_q == OP_DIVU: begin
        res = {ur, uq};
        wr  = (b_q != 32'd0);
      end
`ifdef MULDIV_MAC_EN
      op_q == OP_MADD: begin
        res = {hi, lo} + sprod;
        wr  = 1'b1;
      end
      op_q == OP_MADDU: begin
        res = {hi, lo} + uprod;
        wr  = 1'b1;
      end
      op_q == OP_MSUB: begin
        res = {hi, lo} - sprod;
        wr  = 1'b1;
      end
      op_q == OP_MSUBU: begin
        res = {hi, lo} - uprod;
        wr  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM, operand latch, countdown and HI/LO writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && valid) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= md_op;
            a_q   <= rs_val;
            b_q   <= rt_val;
            cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          end else if (md_op == OP_MTHI) begin
            hi <= rs_val;
          end else if (md_op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (wr) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
